hp_class_arb: RTL and testbench
===============================

# hp_class_arb

Round-robin arbiter and result sequencer that shares one half-precision classifier among `NREQ` requesters. Each requester presents a 16-bit binary16 operand over a valid/ready handshake. The block grants one requester per cycle, classifies the operand through a single `hp_class` instance, and returns a registered one-hot class with the requester ID. It sits between the FP operand sources and any consumer that needs NaN/Inf/zero/subnormal screening before arithmetic.

## Interface
Parameters:
- `NREQ`, default 4, number of requesters (2..16)
- `IDW`, default 2, width of requester ID; must equal ceil(log2(NREQ))
- `CNTW`, default 16, width of each statistics counter

Ports (`clk`, `rst` first):
- `clk` in 1: sole clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in NREQ: per-requester operand valid
- `req_data` in 16*NREQ: operands, requester i at bits [16*i+15:16*i]
- `req_ready` out NREQ: per-requester accept, one-hot or zero
- `res_valid` out 1: result register holds a result
- `res_ready` in 1: consumer accepts result
- `res_id` out IDW: ID of the requester that produced the result
- `res_data` out 16: operand echoed
- `res_class` out 6: one-hot class {snan, qnan, infinity, zero, subnormal, normal}, bit 5 = snan
- `cnt_clear` in 1: clear all statistics counters
- `cnt_sel` in 3: counter select, 0=normal .. 5=snan; 6 and 7 read 0
- `cnt_value` out CNTW: selected counter, combinational read

## Operation
- Output slot is one register with two states: EMPTY (`res_valid`=0) and FULL (`res_valid`=1).
- `free` = EMPTY | (`res_valid` & `res_ready`).
- Grant: when `free` is high, pick the first asserted `req_valid` at or above pointer `ptr`, wrapping NREQ-1 -> 0. `req_ready[g]`=1 for that requester only. `req_ready` is all zero when `free`=0 or no request is pending.
- Acceptance: `req_valid[g]` & `req_ready[g]`. On the next edge, the slot loads `res_data`, `res_id`=g and `res_class`, and `ptr` becomes g+1 mod NREQ.
- No acceptance but drain (`res_valid` & `res_ready`): slot goes EMPTY.
- Accept and drain in the same cycle: slot reloads and stays FULL. No bubble.
- `ptr` holds when no grant occurs.
- Requester rule: once `req_valid` is raised, it stays high and `req_data` stays stable until accepted. Consumer rule: `res_*` are stable while `res_valid`=1 and `res_ready`=0.
- Exactly one `res_class` bit is set whenever `res_valid`=1.
- Negative zero is zero. The sign is ignored for every class.

## Timing
- Reset values: `res_valid`=0, `res_id`=0, `res_data`=0, `res_class`=0, `ptr`=0, all counters 0. `req_ready` is combinational and 0 during `rst`.
- Latency: accepted in cycle N -> `res_valid`=1 in cycle N+1.
- Throughput: 1 result/cycle with `res_ready` held high.
- `rst` asserted mid-operation: the held result is discarded with no drain, and un-accepted requests remain pending in their requesters. The first grant after reset goes to the lowest-index requester.
- `req_ready` depends combinationally on `res_ready`. There is no combinational path from `req_data` to any output.

## Configuration
- `HP_CLASS_ARB_STATS_EN` defined: six CNTW-bit saturating counters, one per class.
  - A counter increments on each result handshake (`res_valid` & `res_ready`) for the class of that result, not on acceptance.
  - A counter holds at all-ones.
  - `cnt_clear` zeroes all six counters on the next edge; clear wins over a simultaneous increment.
- Not defined: no counter flops, `cnt_value` is tied to 0, and `cnt_clear`/`cnt_sel` are ignored. Ports are present in both builds.

## Structure
- Shared package `hp_class_pkg`:
  - class bit-index constants (SNAN=5 .. NORMAL=0)
  - the 6-bit class typedef
  - binary16 field widths (EXP=5, SIG=10)
- One sub-module: the existing `hp_class`, instantiated once on the granted operand mux output. Its six outputs are concatenated into `res_class` in the package bit order.
- Arbiter, pointer, slot register and counters stay in the top module.

## Test plan
- Single requester 1, `res_ready`=1, operands 0x3C00, 0x7C00, 0x8000, 0x0001, 0x7E00, 0x7D00 on consecutive cycles -> classes normal, infinity, zero, subnormal, qnan, snan (0x01, 0x08, 0x04, 0x02, 0x10, 0x20), one per cycle, `res_id`=1, 1-cycle latency.
- All 4 requesters valid continuously, `res_ready`=1 -> grant order 0,1,2,3,0,... and `res_id` sequence matches.
- `res_ready`=0 for 3 cycles with the slot FULL -> `req_ready`=0 and `res_*` unchanged. `res_ready`=1 -> accept and drain in the same cycle, no bubble.
- Assert `rst` while FULL, with `ptr`=2 and requests pending -> next cycle `res_valid`=0, then grant to requester 0.
- With `HP_CLASS_ARB_STATS_EN`: 3 snan results -> `cnt_sel`=5 reads 3. `cnt_clear` on the same cycle as a snan handshake -> reads 0. With CNTW=2, 5 normals -> reads 3.
- Without the macro: the same traffic -> `cnt_value`=0 for every `cnt_sel`.

Source files
------------

// File: rtl/hp_class_pkg.sv
// Shared binary16 classification definitions: field widths, class bit
// indices and the one-hot class type used by hp_class and hp_class_arb.
package hp_class_pkg;
    localparam int FP_W  = 16;
    localparam int EXP_W = 5;
    localparam int SIG_W = 10;

    localparam int CLS_NORMAL    = 0;
    localparam int CLS_SUBNORMAL = 1;
    localparam int CLS_ZERO      = 2;
    localparam int CLS_INF       = 3;
    localparam int CLS_QNAN      = 4;
    localparam int CLS_SNAN      = 5;
    localparam int CLS_W         = 6;

    typedef logic [CLS_W-1:0] hp_cls_t;
endpackage

// File: rtl/hp_class.sv
// Combinational binary16 classifier; exactly one output is high for any operand.
// The sign bit does not affect the class.
module hp_class
    import hp_class_pkg::*;
(
    input  logic [FP_W-1:0] data,
    output logic            snan,
    output logic            qnan,
    output logic            infinity,
    output logic            zero,
    output logic            subnormal,
    output logic            normal
);
    logic [EXP_W-1:0] exp_f;
    logic [SIG_W-1:0] sig_f;
    logic             exp_max;
    logic             exp_min;
    logic             sig_nz;
    logic             unused_sign;

    assign exp_f       = data[FP_W-2 -: EXP_W];
    assign sig_f       = data[SIG_W-1:0];
    assign unused_sign = data[FP_W-1];
    assign exp_max     = &exp_f;
    assign exp_min     = ~|exp_f;
    assign sig_nz      = |sig_f;

    // Quiet/signalling NaNs differ only in the top significand bit.
    assign snan      = exp_max &  sig_nz & ~sig_f[SIG_W-1];
    assign qnan      = exp_max &  sig_nz &  sig_f[SIG_W-1];
    assign infinity  = exp_max & ~sig_nz;
    assign zero      = exp_min & ~sig_nz;
    assign subnormal = exp_min &  sig_nz;
    assign normal    = ~exp_max & ~exp_min;
endmodule

// File: rtl/hp_class_arb.sv
// Round-robin arbiter sharing one hp_class among NREQ requesters, with a
// single-entry result slot. Define HP_CLASS_ARB_STATS_EN for per-class counters.
module hp_class_arb
    import hp_class_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [16*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic [15:0]       res_data,
    output logic [5:0]        res_class,
    input  logic              cnt_clear,
    input  logic [2:0]        cnt_sel,
    output logic [CNTW-1:0]   cnt_value
);
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  cand;
    logic [IDW-1:0]  gnt_id;
    logic            found;
    logic            free;
    logic            accept;
    logic            drain;
    logic [15:0]     operand;
    hp_cls_t         cls;

    // Search starts at ptr and wraps, so the last winner has lowest priority.
    always_comb begin
        gnt_id = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
    end

    assign free   = !res_valid || res_ready;
    assign accept = found && free && !rst;
    assign drain  = res_valid && res_ready;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_id] = 1'b1;
    end

    assign operand = req_data[{gnt_id, 4'b0000} +: 16];

    hp_class u_class (
        .data      (operand),
        .snan      (cls[CLS_SNAN]),
        .qnan      (cls[CLS_QNAN]),
        .infinity  (cls[CLS_INF]),
        .zero      (cls[CLS_ZERO]),
        .subnormal (cls[CLS_SUBNORMAL]),
        .normal    (cls[CLS_NORMAL])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            res_class <= '0;
            ptr       <= '0;
        end else if (accept) begin
            // A simultaneous drain is absorbed here: the slot simply reloads.
            res_valid <= 1'b1;
            res_id    <= gnt_id;
            res_data  <= operand;
            res_class <= cls;
            ptr       <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end else if (drain) begin
            res_valid <= 1'b0;
        end
    end

`ifdef HP_CLASS_ARB_STATS_EN
    logic [CNTW-1:0] cnt [CLS_W];

    // Counting happens on the result handshake; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            for (int k = 0; k < CLS_W; k++) cnt[k] <= '0;
        end else if (drain) begin
            for (int k = 0; k < CLS_W; k++) begin
                if (res_class[k] && (cnt[k] != {CNTW{1'b1}})) cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_value = '0;
        for (int k = 0; k < CLS_W; k++) begin
            if (cnt_sel == 3'(k)) cnt_value = cnt[k];
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{cnt_clear, cnt_sel};
    assign cnt_value    = '0;
`endif
endmodule

// File: tb/tb_hp_class_arb.sv
// Directed bench for hp_class_arb: classification, round-robin order,
// back-pressure, mid-operation reset and statistics counters.
module tb_hp_class_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [15:0] res_data;
    logic [5:0]  res_class;
    logic        cnt_clear;
    logic [2:0]  cnt_sel;
    logic [15:0] cnt_value;

    logic [3:0]  s_req_valid;
    logic [63:0] s_req_data;
    logic [3:0]  s_req_ready;
    logic        s_res_valid;
    logic        s_res_ready;
    logic [1:0]  s_res_id;
    logic [15:0] s_res_data;
    logic [5:0]  s_res_class;
    logic        s_cnt_clear;
    logic [2:0]  s_cnt_sel;
    logic [1:0]  s_cnt_value;

    int errors = 0;
    int checks = 0;

`ifdef HP_CLASS_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [15:0] CLS_OPS [11] = '{16'h3C00, 16'h7C00, 16'h8000, 16'h0001, 16'h7E00,
        16'h7D00, 16'hFC00, 16'hFE01, 16'h83FF, 16'h7BFF, 16'hFD00};
    localparam logic [5:0]  CLS_EXP [11] = '{6'h01, 6'h08, 6'h04, 6'h02, 6'h10,
        6'h20, 6'h08, 6'h10, 6'h02, 6'h01, 6'h20};

    hp_class_arb #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_data(res_data), .res_class(res_class),
        .cnt_clear(cnt_clear), .cnt_sel(cnt_sel), .cnt_value(cnt_value)
    );

    hp_class_arb #(.NREQ(4), .IDW(2), .CNTW(2)) u_sat (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_data(s_req_data),
        .req_ready(s_req_ready), .res_valid(s_res_valid), .res_ready(s_res_ready),
        .res_id(s_res_id), .res_data(s_res_data), .res_class(s_res_class),
        .cnt_clear(s_cnt_clear), .cnt_sel(s_cnt_sel), .cnt_value(s_cnt_value)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        step();
        step();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got=%b exp=0000", req_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", res_valid); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL rst_id got=%0d exp=0", res_id); end
        checks++; if (res_data !== 16'h0) begin errors++; $display("FAIL rst_data got=%h exp=0000", res_data); end
        checks++; if (res_class !== 6'h0) begin errors++; $display("FAIL rst_class got=%h exp=00", res_class); end
        checks++; if (cnt_value !== 16'h0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cnt_value); end
        req_valid = 4'b0000;
        rst = 1'b0;
        step();
    endtask

    task automatic test_classes();
        res_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            req_valid = 4'b0010;
            req_data[31:16] = CLS_OPS[k];
            #1;
            checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL cls_ready[%0d] got=%b exp=0010", k, req_ready); end
            step();
            checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== CLS_OPS[k])
                begin errors++; $display("FAIL cls_res[%0d] got v=%b id=%0d d=%h exp v=1 id=1 d=%h", k, res_valid, res_id, res_data, CLS_OPS[k]); end
            checks++; if (res_class !== CLS_EXP[k]) begin errors++; $display("FAIL cls_class[%0d] op=%h got=%h exp=%h", k, CLS_OPS[k], res_class, CLS_EXP[k]); end
        end
        req_valid = 4'b0000;
        step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL cls_drain got=%b exp=0", res_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        res_ready = 1'b1;
        req_data = {16'h3C03, 16'h3C02, 16'h3C01, 16'h3C00};
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << (c % 4))) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, 4'b0001 << (c % 4)); end
            step();
            checks++; if (res_valid !== 1'b1 || res_id !== 2'(c % 4) || res_data !== 16'h3C00 + 16'(c % 4))
                begin errors++; $display("FAIL rr_res[%0d] got v=%b id=%0d d=%h exp id=%0d", c, res_valid, res_id, res_data, c % 4); end
        end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_back_pressure();
        res_ready = 1'b1;
        req_data[47:32] = 16'h7C00;
        req_valid = 4'b0100;
        step();
        req_valid = 4'b1000;
        req_data[63:48] = 16'h0001;
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
            checks++; if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== 16'h7C00 || res_class !== 6'h08)
                begin errors++; $display("FAIL bp_hold[%0d] got v=%b id=%0d d=%h c=%h exp v=1 id=2 d=7c00 c=08", c, res_valid, res_id, res_data, res_class); end
            step();
        end
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release got=%b exp=1000", req_ready); end
        step();
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_class !== 6'h02)
            begin errors++; $display("FAIL bp_nobubble got v=%b id=%0d c=%h exp v=1 id=3 c=02", res_valid, res_id, res_class); end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b1;
        req_data = {16'h3C03, 16'h3C02, 16'h3C01, 16'h3C00};
        req_valid = 4'b0010;
        step();
        res_ready = 1'b0;
        req_valid = 4'b1111;
        step();
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
        step();
        rst = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", res_valid); end
        res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
        step();
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 16'h3C00)
            begin errors++; $display("FAIL mid_first_res got v=%b id=%0d d=%h exp v=1 id=0 d=3c00", res_valid, res_id, res_data); end
        req_valid = 4'b0000;
        step();
    endtask

    task automatic test_stats();
        do_reset();
        res_ready = 1'b1;
        req_data[15:0] = 16'h7D00;
        req_valid = 4'b0001;
        step(); step(); step();
        req_valid = 4'b0000;
        step();
        for (int s = 0; s < 8; s++) begin
            cnt_sel = 3'(s);
            #1;
            checks++; if (cnt_value !== ((STATS && s == 5) ? 16'd3 : 16'd0))
                begin errors++; $display("FAIL stats_sel[%0d] got=%0d exp=%0d", s, cnt_value, (STATS && s == 5) ? 3 : 0); end
        end
        cnt_sel = 3'd5;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0000;
        checks++; if (cnt_value !== (STATS ? 16'd3 : 16'd0)) begin errors++; $display("FAIL stats_on_accept got=%0d exp=%0d", cnt_value, STATS ? 3 : 0); end
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        checks++; if (cnt_value !== 16'd0) begin errors++; $display("FAIL stats_clear_wins got=%0d exp=0", cnt_value); end
    endtask

    task automatic test_saturate();
        s_req_data[15:0] = 16'h3C00;
        s_req_valid = 4'b0001;
        for (int c = 0; c < 5; c++) step();
        s_req_valid = 4'b0000;
        step();
        step();
        checks++; if (s_cnt_value !== (STATS ? 2'd3 : 2'd0)) begin errors++; $display("FAIL sat_cnt got=%0d exp=%0d", s_cnt_value, STATS ? 3 : 0); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_data = '0; res_ready = 1'b1;
        cnt_clear = 1'b0; cnt_sel = 3'd0;
        s_req_valid = '0; s_req_data = '0; s_res_ready = 1'b1;
        s_cnt_clear = 1'b0; s_cnt_sel = 3'd0;
        test_reset();
        test_classes();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
        test_stats();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
